// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the address/branch unit (port 1).
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP returns the result.
module alu_arbiter #(
   parameter int DATA_W    = 32,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_a_i,
   input  logic [DATA_W-1:0] req0_b_i,
   input  logic [2:0]        req0_funct3_i,
   input  logic              req0_funct7_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_a_i,
   input  logic [DATA_W-1:0] req1_b_i,
   input  logic [2:0]        req1_funct3_i,
   input  logic              req1_funct7_i,
   output logic              rsp0_valid_o,
   input  logic              rsp0_ready_i,
   output logic              rsp1_valid_o,
   input  logic              rsp1_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [2:0]        alu_funct3_o,
   output logic              alu_funct7_o,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [2:0]          r_funct3;
   logic                r_funct7;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_owner;
   logic                r_last_grant;
   logic                w_grant;
   logic                w_accept;
   logic                w_rsp_ready;

   // Contention resolves to the port that did not win last time, unless port 0 is fixed winner.
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         w_grant = PRIO_MODE ? 1'b0 : ~r_last_grant;
      end else if (req1_valid_i) begin
         w_grant = 1'b1;
      end
   end

   assign w_rsp_ready = r_owner ? rsp1_ready_i : rsp0_ready_i;

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      req0_ready_o = 1'b0;
      req1_ready_o = 1'b0;
      case (r_state)
         IDLE: begin
            if (req0_valid_i || req1_valid_i) begin
               req0_ready_o = ~w_grant;
               req1_ready_o = w_grant;
               w_accept     = 1'b1;
               w_state_nxt  = EXEC;
            end
         end
         EXEC: w_state_nxt = RESP;
         RESP: begin
            if (w_rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a        <= '0;
         r_b        <= '0;
         r_funct3   <= '0;
         r_funct7   <= 1'b0;
         r_rsp_data <= '0;
      end else begin
         if (w_accept) begin
            r_a      <= w_grant ? req1_a_i      : req0_a_i;
            r_b      <= w_grant ? req1_b_i      : req0_b_i;
            r_funct3 <= w_grant ? req1_funct3_i : req0_funct3_i;
            r_funct7 <= w_grant ? req1_funct7_i : req0_funct7_i;
         end
         // The ALU is combinational, so its result is valid during the EXEC cycle.
         if (r_state == EXEC) begin
            r_rsp_data <= alu_result_i;
         end
      end
   end

   assign alu_a_o      = r_a;
   assign alu_b_o      = r_b;
   assign alu_funct3_o = r_funct3;
   assign alu_funct7_o = r_funct7;
   assign rsp_data_o   = r_rsp_data;
   assign rsp0_valid_o = (r_state == RESP) && !r_owner;
   assign rsp1_valid_o = (r_state == RESP) && r_owner;
   assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin (u0) and fixed-priority (u1) instances share all stimulus;
// expected responses are queued per instance and popped by a monitor on each response handshake.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_f3, req1_f3;
   logic        req0_f7, req1_f7;
   logic        rsp0_ready, rsp1_ready;

   logic        d0_req0_ready, d0_req1_ready, d0_rsp0_valid, d0_rsp1_valid, d0_busy, d0_f7;
   logic [31:0] d0_rsp_data, d0_a, d0_b, d0_res;
   logic [2:0]  d0_f3;
   logic        d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid, d1_busy, d1_f7;
   logic [31:0] d1_rsp_data, d1_a, d1_b, d1_res;
   logic [2:0]  d1_f3;

   int errors = 0;
   int checks = 0;
   logic [32:0] q0[$];
   logic [32:0] q1[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] f3, logic f7);
      case (f3)
         3'd0: alu_f = f7 ? a - b : a + b;
         3'd1: alu_f = a << b[4:0];
         3'd2: alu_f = {31'd0, $signed(a) < $signed(b)};
         3'd3: alu_f = {31'd0, a < b};
         3'd4: alu_f = a ^ b;
         3'd5: alu_f = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: alu_f = a | b;
         default: alu_f = a & b;
      endcase
   endfunction

   assign d0_res = alu_f(d0_a, d0_b, d0_f3, d0_f7);
   assign d1_res = alu_f(d1_a, d1_b, d1_f3, d1_f7);

   alu_arbiter #(.DATA_W(32), .PRIO_MODE(1'b0)) u0 (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(d0_req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
      .req0_funct3_i(req0_f3), .req0_funct7_i(req0_f7),
      .req1_valid_i(req1_valid), .req1_ready_o(d0_req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
      .req1_funct3_i(req1_f3), .req1_funct7_i(req1_f7),
      .rsp0_valid_o(d0_rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp1_valid_o(d0_rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp_data_o(d0_rsp_data), .alu_a_o(d0_a), .alu_b_o(d0_b), .alu_funct3_o(d0_f3),
      .alu_funct7_o(d0_f7), .alu_result_i(d0_res), .busy_o(d0_busy)
   );

   alu_arbiter #(.DATA_W(32), .PRIO_MODE(1'b1)) u1 (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(d1_req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b),
      .req0_funct3_i(req0_f3), .req0_funct7_i(req0_f7),
      .req1_valid_i(req1_valid), .req1_ready_o(d1_req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b),
      .req1_funct3_i(req1_f3), .req1_funct7_i(req1_f7),
      .rsp0_valid_o(d1_rsp0_valid), .rsp0_ready_i(rsp0_ready),
      .rsp1_valid_o(d1_rsp1_valid), .rsp1_ready_i(rsp1_ready),
      .rsp_data_o(d1_rsp_data), .alu_a_o(d1_a), .alu_b_o(d1_b), .alu_funct3_o(d1_f3),
      .alu_funct7_o(d1_f7), .alu_result_i(d1_res), .busy_o(d1_busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every response handshake must match the head of that instance's queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (d0_rsp0_valid && d0_rsp1_valid) chk("u0 both rsp valid", 1, 0);
         if (d1_rsp0_valid && d1_rsp1_valid) chk("u1 both rsp valid", 1, 0);
         if ((d0_rsp0_valid && rsp0_ready) || (d0_rsp1_valid && rsp1_ready)) begin
            if (q0.size() == 0) chk("u0 unexpected rsp", {d0_rsp1_valid, d0_rsp_data}, 64'hDEAD);
            else chk("u0 rsp port/data", {d0_rsp1_valid, d0_rsp_data}, q0.pop_front());
         end
         if ((d1_rsp0_valid && rsp0_ready) || (d1_rsp1_valid && rsp1_ready)) begin
            if (q1.size() == 0) chk("u1 unexpected rsp", {d1_rsp1_valid, d1_rsp_data}, 64'hDEAD);
            else chk("u1 rsp port/data", {d1_rsp1_valid, d1_rsp_data}, q1.pop_front());
         end
      end
   end

   task automatic expect_both(input logic port, input logic [31:0] data);
      q0.push_back({port, data});
      q1.push_back({port, data});
   endtask

   task automatic do_req(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic f7);
      bit ok;
      @(posedge clk); #1;
      if (port) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f3 = f3; req1_f7 = f7;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f3 = f3; req0_f7 = f7;
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (port ? d0_req1_ready : d0_req0_ready) begin ok = 1'b1; break; end
      end
      chk("req accepted", ok, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!d0_busy && !d1_busy) begin ok = 1'b1; break; end
      end
      chk("return to idle", ok, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic        v_port [5];
   logic [31:0] v_a    [5];
   logic [31:0] v_b    [5];
   logic [2:0]  v_f3   [5];
   logic        v_f7   [5];
   logic [31:0] v_exp  [5];

   initial begin
      v_port = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      v_a    = '{32'd3, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
      v_b    = '{32'd5, 32'd4, 32'd4, 32'd1, 32'h0FF0_0FF0};
      v_f3   = '{3'd0, 3'd5, 3'd5, 3'd2, 3'd7};
      v_f7   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      v_exp  = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'h00F0_00F0};

      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_f3 = '0; req0_f7 = 1'b0;
      req1_a = '0; req1_b = '0; req1_f3 = '0; req1_f7 = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      #1;
      chk("reset busy", d0_busy, 0);
      chk("reset rsp valids", {d0_rsp0_valid, d0_rsp1_valid}, 0);
      chk("reset rsp_data", d0_rsp_data, 0);
      chk("reset alu regs", {d0_a, d0_b, d0_f3, d0_f7}, 0);
      chk("reset req ready", {d0_req0_ready, d0_req1_ready}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single port-0 add with cycle-exact latency
      expect_both(1'b0, 32'd8);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_f3 = 3'd0; req0_f7 = 1'b0;
      @(negedge clk);
      chk("N req0 ready", d0_req0_ready, 1);
      chk("N req1 ready", d0_req1_ready, 0);
      chk("N busy", d0_busy, 0);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk("N+1 busy", d0_busy, 1);
      chk("N+1 rsp0 valid", d0_rsp0_valid, 0);
      chk("N+1 alu operands", {d0_a, d0_b}, {32'd5, 32'd3});
      @(negedge clk);
      chk("N+2 rsp0 valid", d0_rsp0_valid, 1);
      chk("N+2 rsp1 valid", d0_rsp1_valid, 0);
      chk("N+2 rsp data", d0_rsp_data, 32'd8);
      @(negedge clk);
      chk("N+3 idle", d0_busy, 0);

      for (int i = 0; i < 5; i++) begin
         expect_both(v_port[i], v_exp[i]);
         do_req(v_port[i], v_a[i], v_b[i], v_f3[i], v_f7[i]);
         wait_idle();
      end

      // Response backpressure with port 1 waiting
      expect_both(1'b0, 32'd1);
      expect_both(1'b1, 32'd2);
      rsp0_ready = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd6; req0_f3 = 3'd4; req0_f7 = 1'b0;
      @(negedge clk);
      chk("bp req0 ready", d0_req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_f3 = 3'd0; req1_f7 = 1'b0;
      @(negedge clk);
      chk("exec req1 ready", d0_req1_ready, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp rsp0 valid", d0_rsp0_valid, 1);
         chk("bp rsp data", d0_rsp_data, 32'd1);
         chk("bp req readies", {d0_req0_ready, d0_req1_ready, d1_req0_ready, d1_req1_ready}, 0);
         chk("bp busy", d0_busy, 1);
      end
      @(posedge clk); #1 rsp0_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp released idle", d0_busy, 0);
      chk("bp req1 ready", d0_req1_ready, 1);
      @(posedge clk); #1 req1_valid = 1'b0;
      wait_idle();

      // Contention: u0 alternates, u1 always port 0
      q0.push_back({1'b0, 32'd11}); q0.push_back({1'b1, 32'd22});
      q0.push_back({1'b0, 32'd11}); q0.push_back({1'b1, 32'd22});
      repeat (4) q1.push_back({1'b0, 32'd11});
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_f3 = 3'd0; req0_f7 = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_f3 = 3'd0; req1_f7 = 1'b0;
      repeat (11) @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("u0 four grants in 12 cycles", q0.size(), 0);
      chk("u1 four grants in 12 cycles", q1.size(), 0);
      chk("contention idle", d0_busy, 0);

      // Reset pulse during RESP discards the operation
      rsp0_ready = 1'b0;
      do_req(1'b0, 32'd9, 32'd9, 3'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset rsp0 valid", d0_rsp0_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid-reset valids", {d0_rsp0_valid, d0_rsp1_valid, d1_rsp0_valid, d1_rsp1_valid}, 0);
      chk("mid-reset busy", d0_busy, 0);
      chk("mid-reset rsp_data", d0_rsp_data, 0);
      chk("mid-reset req ready", {d0_req0_ready, d0_req1_ready}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; rsp0_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no stale rsp", {d0_rsp0_valid, d0_rsp1_valid, d0_busy}, 0);
      end
      expect_both(1'b0, 32'd11);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_f3 = 3'd0; req0_f7 = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_f3 = 3'd0; req1_f7 = 1'b0;
      @(negedge clk);
      chk("post-reset grant port0", {d0_req0_ready, d0_req1_ready}, 2'b10);
      @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      chk("u0 queue drained", q0.size(), 0);
      chk("u1 queue drained", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single execute-stage ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch-target unit. Each requester hands over operands and funct3/funct7 through a valid/ready request channel. The block arbitrates, registers the operands, drives the ALU, captures the result, and returns it on that requester's valid/ready response channel. Exactly one operation is in flight at a time.

Parameters:
DATA_W, 32, operand/result width; must match the ALU width (32 in this core)
PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins

Ports:
clk_i  input  1  core clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
req0_valid_i  input  1  port 0 request valid
req0_ready_o  output  1  port 0 request accepted this cycle when high with valid
req0_a_i  input  DATA_W  port 0 operand A
req0_b_i  input  DATA_W  port 0 operand B
req0_funct3_i  input  3  port 0 ALU op select
req0_funct7_i  input  1  port 0 sub/arith-shift select
req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_funct3_i, req1_funct7_i  same as port 0, for port 1
rsp0_valid_o  output  1  port 0 result valid
rsp0_ready_i  input  1  port 0 result accepted
rsp1_valid_o  output  1  port 1 result valid
rsp1_ready_i  input  1  port 1 result accepted
rsp_data_o  output  DATA_W  result, shared by both response channels
alu_a_o  output  DATA_W  to ALU input0
alu_b_o  output  DATA_W  to ALU input1
alu_funct3_o  output  3  to ALU funct3
alu_funct7_o  output  1  to ALU funct7
alu_result_i  input  DATA_W  from ALU output (combinational)
busy_o  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, EXEC, RESP. Reset (rst_ni low, asynchronous) forces:
  - IDLE; all ALU operand/op registers = 0; rsp_data_o = 0
  - rsp0_valid_o = rsp1_valid_o = 0; busy_o = 0
  - owner = 0; last_grant = 1, so port 0 wins the first contention
- IDLE:
  - req*_ready_o is combinational and high only in IDLE, and only for the granted port.
  - Grant when only one port is valid: that port.
  - Grant when both are valid: PRIO_MODE=0 picks the port not equal to last_grant; PRIO_MODE=1 picks port 0.
  - On a handshake: latch a, b, funct3, funct7 into the ALU registers; set owner = granted port; set last_grant = granted port; go to EXEC.
  - No valid request: stay in IDLE; ALU registers hold their last values.
- EXEC (one cycle):
  - alu_*_o are driven directly from the registers.
  - At the clock edge, rsp_data_o <= alu_result_i; go to RESP.
- RESP:
  - rsp<owner>_valid_o = 1; the other rsp valid stays 0.
  - rsp_data_o is stable until the handshake. Valid must not drop without ready.
  - On rsp<owner>_ready_i = 1: go to IDLE. The next request can be accepted in the following cycle, not the same cycle.
- Latency and throughput:
  - Request handshake in cycle N, EXEC in N+1, rsp valid from N+2.
  - Minimum 3 cycles per operation.
- A requester may change or drop its request while not granted; no state is kept for it.
- Ready of the non-owner port is 0 in EXEC and RESP.
- rsp*_ready_i arriving while its valid is 0 is ignored.
- Width: operands and result are passed through unmodified. Carry is not forwarded.
- Reset asserted mid-EXEC or mid-RESP: the in-flight operation is discarded and no response is issued after reset release.

Test Plan:
- Single request, port 0: a=5, b=3, funct3=0, funct7=0 -> ready high in cycle N, busy_o high N+1, rsp0_valid_o high at N+2 with rsp_data_o=8; rsp1_valid_o stays 0.
- Port 1 subtract: a=3, b=5, f3=0, f7=1 -> rsp1_valid_o with rsp_data_o=0xFFFFFFFE.
- Contention, PRIO_MODE=0, both ports valid continuously, rsp ready always 1 -> grants alternate 0,1,0,1, one every 3 cycles.
- Same contention with PRIO_MODE=1 -> port 0 granted every time, port 1 never.
- Response backpressure: hold rsp0_ready_i=0 for 5 cycles -> rsp0_valid_o and rsp_data_o stable, both req ready low, busy_o=1; release -> IDLE on the next cycle.
- Reset pulse during RESP -> all valids/ready 0 immediately, rsp_data_o=0, no stale response after release; the first later contention grants port 0.
